// File: rtl/predict_dispatcher_pkg.sv
// Shared definitions for the digit-predictor dispatcher.
// Holds the bitmap geometry, board size, digit width, blank-cell threshold and
// the dispatcher FSM state encoding. Imported by predict_dispatcher and row_popcount.
package predict_dispatcher_pkg;

  localparam int unsigned CELL_W     = 52;  // bitmap side; one RAM word per bitmap row
  localparam int unsigned N_CELLS    = 81;  // cells per board, row-major
  localparam int unsigned ADDR_W     = 13;  // holds N_CELLS*CELL_W-1 = 4211
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BLANK_TH   = 20;  // set-pixel count below which a cell is blank
  localparam int unsigned ROW_W      = 6;   // row counter width, covers 0..CELL_W-1
  localparam int unsigned CELL_IDX_W = 7;   // cell counter width, covers 0..N_CELLS-1
  localparam int unsigned POP_W      = 6;   // per-row popcount, max CELL_W
  localparam int unsigned CNT_W      = 12;  // per-cell pixel count, max CELL_W*CELL_W

  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_e;

endpackage

// File: rtl/predict_dispatcher_row_popcount.sv
// row_popcount: combinational count of set pixels in one bitmap row.
// Only used when SKIP_BLANK_EN is defined, so the module body is built only then.
// Ports:
//   row_data  in   CELL_W   one bitmap row
//   count     out  POP_W    number of set bits in row_data
`ifdef SKIP_BLANK_EN
module row_popcount
  import predict_dispatcher_pkg::*;
(
  input  logic [CELL_W-1:0] row_data,
  output logic [POP_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CELL_W; i++) begin
      count = count + POP_W'(row_data[i]);
    end
  end

endmodule
`endif

// File: rtl/predict_dispatcher.sv
// predict_dispatcher: initiator side of the digit-predictor handshake.
// On go, walks all N_CELLS cells in order. For each cell it reads the CELL_W x CELL_W bitmap
// row by row from the cell-image RAM, presents the assembled bitmap to the predictor, pulses
// pred_start, waits for pred_finish and writes the returned digit into the packed board.
// Optional feature macro: SKIP_BLANK_EN -- cells with fewer than BLANK_TH set pixels bypass the
// predictor and store BLANK_DIGIT.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   go             start a board pass (sampled only in IDLE)
//   mem_rd         RAM read strobe
//   mem_addr       RAM address = cell*CELL_W + row
//   mem_rdata      RAM row data, valid one cycle after mem_rd
//   pred_start     one-cycle start pulse to the predictor
//   track_input    assembled bitmap, bit [r*CELL_W+c] = pixel (r, c)
//   pred_number    predicted digit, sampled with pred_finish
//   pred_finish    one-cycle completion pulse from the predictor
//   board          digit of cell i at [i*4 +: 4]
//   cell_idx       cell currently being processed
//   busy           high outside IDLE
//   done           one-cycle pulse when the board is complete
module predict_dispatcher
  import predict_dispatcher_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  output logic                         mem_rd,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [CELL_W-1:0]            mem_rdata,
  output logic                         pred_start,
  output logic [CELL_W*CELL_W-1:0]     track_input,
  input  logic [DIGIT_W-1:0]           pred_number,
  input  logic                         pred_finish,
  output logic [DIGIT_W*N_CELLS-1:0]   board,
  output logic [CELL_IDX_W-1:0]        cell_idx,
  output logic                         busy,
  output logic                         done
);

  localparam logic [ROW_W-1:0]      RowLast  = ROW_W'(CELL_W - 1);
  localparam logic [CELL_IDX_W-1:0] CellLast = CELL_IDX_W'(N_CELLS - 1);

  state_e                       state_q, state_d;
  logic [CELL_IDX_W-1:0]        cell_q;
  logic [ROW_W-1:0]             row_q;
  logic [ROW_W-1:0]             cap_row_q;  // row whose data arrives this cycle
  logic                         cap_vld_q;  // mem_rdata holds a requested row
  logic [CELL_W*CELL_W-1:0]     track_q;
  logic [DIGIT_W*N_CELLS-1:0]   board_q;
  logic [DIGIT_W-1:0]           num_q;
  logic [ADDR_W-1:0]            cell_base;

`ifdef SKIP_BLANK_EN
  logic [POP_W-1:0] row_pop;
  logic [CNT_W-1:0] cnt_q;
  logic             is_blank;

  row_popcount u_row_popcount (
    .row_data (mem_rdata),
    .count    (row_pop)
  );

  assign is_blank = cnt_q < CNT_W'(BLANK_TH);
`endif

  assign cell_base   = ADDR_W'(cell_q) * ADDR_W'(CELL_W);
  assign mem_addr    = (state_q == S_FETCH) ? cell_base + ADDR_W'(row_q) : '0;
  assign track_input = track_q;
  assign board       = board_q;
  assign cell_idx    = cell_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_rd     = 1'b0;
    pred_start = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (row_q == RowLast) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_START;
      end
      S_START: begin
`ifdef SKIP_BLANK_EN
        if (is_blank) begin
          state_d = S_STORE;
        end else begin
          pred_start = 1'b1;
          state_d    = S_WAIT;
        end
`else
        pred_start = 1'b1;
        state_d    = S_WAIT;
`endif
      end
      S_WAIT: begin
        if (pred_finish) state_d = S_STORE;
      end
      S_STORE: begin
        state_d = (cell_q == CellLast) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_q    <= '0;
      row_q     <= '0;
      cap_row_q <= '0;
      cap_vld_q <= 1'b0;
      track_q   <= '0;
      board_q   <= '0;
      num_q     <= '0;
`ifdef SKIP_BLANK_EN
      cnt_q     <= '0;
`endif
    end else begin
      // Read data lags the strobe by one cycle; a delayed copy of row places it.
      cap_vld_q <= mem_rd;
      cap_row_q <= row_q;
      if (cap_vld_q) begin
        track_q[int'(cap_row_q)*CELL_W +: CELL_W] <= mem_rdata;
      end
`ifdef SKIP_BLANK_EN
      if (cap_vld_q) begin
        cnt_q <= cnt_q + CNT_W'(row_pop);
      end
`endif

      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            cell_q <= '0;
            row_q  <= '0;
`ifdef SKIP_BLANK_EN
            cnt_q  <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (row_q != RowLast) row_q <= row_q + ROW_W'(1);
        end
`ifdef SKIP_BLANK_EN
        S_START: begin
          if (is_blank) num_q <= BLANK_DIGIT;
        end
`endif
        S_WAIT: begin
          if (pred_finish) num_q <= pred_number;
        end
        S_STORE: begin
          board_q[int'(cell_q)*DIGIT_W +: DIGIT_W] <= num_q;
          if (cell_q != CellLast) begin
            cell_q <= cell_q + CELL_IDX_W'(1);
            row_q  <= '0;
`ifdef SKIP_BLANK_EN
            cnt_q  <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_predict_dispatcher.sv
// Directed self-checking bench for predict_dispatcher with a behavioural cell RAM and a
// fixed-latency predictor model.
module tb_predict_dispatcher;
  import predict_dispatcher_pkg::*;

  localparam int TW = CELL_W * CELL_W;
  localparam int BW = DIGIT_W * N_CELLS;
  localparam int PASS_CYC = N_CELLS * (CELL_W + 3 + 5) + 1;  // go edge to done cycle
  localparam int LIMIT = 6000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 go = 1'b0;
  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  logic [CELL_W-1:0]    mem_rdata = '0;
  logic                 pred_start;
  logic [TW-1:0]        track_input;
  logic [3:0]           pred_number = '0;
  logic                 pred_finish;
  logic [BW-1:0]        board;
  logic [6:0]           cell_idx;
  logic                 busy;
  logic                 done;

  logic pf_model = 1'b0;
  logic spur = 1'b0;
  assign pred_finish = pf_model | spur;

  int checks = 0;
  int errors = 0;

  int mode = 0;         // RAM content pattern
  bit pd_en = 1'b1;     // predictor answers at all
  bit const_mode = 1'b0;
  int k_base = 0;       // start count at beginning of pass
  int snap_at = -1;     // start count at which to snapshot track_input

  int start_cnt = 0;
  int done_cnt = 0;
  int pd_cnt = 0;
  int pd_k = 0;
  logic [TW-1:0] snap = '0;

  always #5 clk = ~clk;

  predict_dispatcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .pred_start  (pred_start),
    .track_input (track_input),
    .pred_number (pred_number),
    .pred_finish (pred_finish),
    .board       (board),
    .cell_idx    (cell_idx),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [CELL_W-1:0] ram_word(input int a);
    int k = a / CELL_W;
    int r = a % CELL_W;
    logic [CELL_W-1:0] w;
    w = '0;
    case (mode)
      0: w = {CELL_W{r[0]}};
      1: if (a == 3) w[7] = 1'b1;
      2: if (k != 5) w = '1;
      default: w = '0;
    endcase
    return w;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= mem_rd ? ram_word(int'(mem_addr)) : '0;
  end

  // Predictor: finish arrives in the 5th cycle after the start cycle.
  always @(negedge clk) begin
    pf_model = 1'b0;
    if (pd_cnt > 0) begin
      pd_cnt--;
      if (pd_cnt == 0 && pd_en) begin
        pf_model = 1'b1;
        pred_number = const_mode ? 4'd7 : 4'(pd_k % 10);
      end
    end
    if (pred_start) begin
      if (start_cnt == snap_at) snap = track_input;
      pd_k = start_cnt - k_base;
      start_cnt++;
      pd_cnt = 5;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input bit hold_go, input int spur_at, output int n);
    @(negedge clk) go = 1'b1;
    @(negedge clk);
    if (!hold_go) go = 1'b0;
    n = 1;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
      spur = (n == spur_at);
    end
    spur = 1'b0;
    if (hold_go) begin
      @(posedge clk);
      #1 go = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int s0;
    int d0;
    int bad;
    logic [TW-1:0] exp_track;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pred_start", 32'(pred_start), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_cell_idx", 32'(cell_idx), 0);
    checks++;
    assert (board === '0 && track_input === '0) else begin
      errors++;
      $error("FAIL rst_board_track: observed nonzero expected zero");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full pass, odd rows set; digit i%10 per cell
    mode = 0;
    k_base = start_cnt;
    snap_at = start_cnt;
    s0 = start_cnt;
    d0 = done_cnt;
    run_pass(1'b0, -1, n);
    @(negedge clk);
    chk("t1_latency_ok", 32'((n >= PASS_CYC - 2) && (n <= PASS_CYC + 2)), 1);
    chk("t1_done_pulses", 32'(done_cnt - d0), 1);
    chk("t1_starts", 32'(start_cnt - s0), 81);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_done_after", 32'(done), 0);
    for (int i = 0; i < N_CELLS; i++) begin
      chk($sformatf("t1_board[%0d]", i), 32'(board[i*4 +: 4]), 32'(i % 10));
    end
    for (int r = 0; r < CELL_W; r++) begin
      for (int c = 0; c < CELL_W; c++) exp_track[r*CELL_W + c] = r[0];
    end
    checks++;
    assert (snap === exp_track) else begin
      errors++;
      $error("FAIL t1_track_cell0: observed %0d set bits expected %0d", $countones(snap),
             $countones(exp_track));
    end

`ifndef SKIP_BLANK_EN
    // Single pixel (3,7) in cell 0
    mode = 1;
    k_base = start_cnt;
    snap_at = start_cnt;
    run_pass(1'b0, -1, n);
    @(negedge clk);
    chk("t2_pixel_3_7", 32'(snap[3*CELL_W + 7]), 1);
    chk("t2_one_bit", 32'($countones(snap)), 1);
    chk("t2_board0", 32'(board[3:0]), 0);
`endif

    // go held high all pass, spurious finish in FETCH of cell 0, go also high in DONE
    mode = 0;
    k_base = start_cnt;
    snap_at = -1;
    s0 = start_cnt;
    d0 = done_cnt;
    run_pass(1'b1, 10, n);
    repeat (3) @(negedge clk);
    chk("t3_latency", 32'(n), 32'(PASS_CYC));
    chk("t3_done_pulses", 32'(done_cnt - d0), 1);
    chk("t3_starts", 32'(start_cnt - s0), 81);
    chk("t3_idle_after", 32'(busy), 0);
    chk("t3_board80", 32'(board[80*4 +: 4]), 0);
    chk("t3_board79", 32'(board[79*4 +: 4]), 9);

`ifdef SKIP_BLANK_EN
    // Cell 5 empty, all others dense; predictor answers 7
    mode = 2;
    const_mode = 1'b1;
    s0 = start_cnt;
    run_pass(1'b0, -1, n);
    @(negedge clk);
    chk("t5_starts", 32'(start_cnt - s0), 80);
    chk("t5_board5", 32'(board[20 +: 4]), 0);
    chk("t5_board4", 32'(board[16 +: 4]), 7);
    chk("t5_board6", 32'(board[24 +: 4]), 7);
    chk("t5_board80", 32'(board[320 +: 4]), 7);
    const_mode = 1'b0;
    mode = 0;
`endif

    // Reset during WAIT of cell 40
    k_base = start_cnt;
    s0 = start_cnt;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    n = 0;
    while (start_cnt - s0 < 41 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reached_cell40", 32'(start_cnt - s0), 41);
    repeat (2) @(negedge clk);
    chk("t4_in_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_pred_start", 32'(pred_start), 0);
    chk("t4_cell_idx", 32'(cell_idx), 0);
    chk("t4_mem_rd", 32'(mem_rd), 0);
    checks++;
    assert (board === '0 && track_input === '0) else begin
      errors++;
      $error("FAIL t4_board_track: observed nonzero expected zero");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_late_finish_ignored", 32'(busy), 0);
    chk("t4_no_new_start", 32'(start_cnt - s0), 41);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk("t4_restart_rd", 32'(mem_rd), 1);
    chk("t4_restart_addr", 32'(mem_addr), 0);
    chk("t4_restart_cell", 32'(cell_idx), 0);
    do_reset();

    // Predictor never answers
    pd_en = 1'b0;
    s0 = start_cnt;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    n = 0;
    while (start_cnt == s0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_start", 32'(start_cnt - s0), 1);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!busy || pred_start || mem_rd || done) bad++;
    end
    chk("t6_stuck_in_wait", 32'(bad), 0);
    chk("t6_single_start", 32'(start_cnt - s0), 1);
    chk("t6_cell_idx", 32'(cell_idx), 0);
    pd_en = 1'b1;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
